timer_counter_flag: RTL and testbench

Programmable modulo counter/timer with run control, periodic or one-shot mode, a one-cycle terminal-count pulse and a sticky, software-clearable flag. It generalises the fixed-maximum counter-with-flag used for sample and bit timing. It serves as the general timer for the MIPS peripherals, such as UART baud/bit timing and delay generation. The terminal value is a run-time input instead of an elaboration constant, and the count width is parametrised.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/prescaler_tick.sv | 30 +++
 rtl/timer_counter_flag.sv | 110 +++++++++++
 tb/tb_timer_counter_flag.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the programmable timer: state encoding, mode constants, CeilLog2.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    function automatic int CeilLog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Down-counting prescaler: emits a tick every reload+1 enabled cycles; synchronous clear reloads it.
// Only instantiated when TIMER_PRESCALER_EN is defined.
module prescaler_tick #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] reload,
    output logic             tick
);

    logic [WIDTH-1:0] remaining;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
        end else if (clear) begin
            remaining <= reload;
        end else if (enable) begin
            if (remaining == '0) remaining <= reload;
            else                 remaining <= remaining - 1'b1;
        end
    end

    assign tick = enable && (remaining == '0);

endmodule

// File: rtl/timer_counter_flag.sv
// Programmable modulo timer with periodic/one-shot mode, one-cycle tc pulse and sticky flag.
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module timer_counter_flag
    import timer_pkg::*;
#(
    parameter int NBITS = 16
`ifdef TIMER_PRESCALER_EN
  , parameter int PRESCALE_BITS = 8
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     mode,
    input  logic [NBITS-1:0]         limit,
`ifdef TIMER_PRESCALER_EN
    input  logic [PRESCALE_BITS-1:0] prescale,
`endif
    input  logic                     clear_flag,
    output logic [NBITS-1:0]         count,
    output logic                     tc,
    output logic                     flag,
    output logic                     busy
);

    timer_state_t     state, state_next;
    logic [NBITS-1:0] count_next;
    logic [NBITS-1:0] limit_q;
    logic [NBITS-1:0] terminal_value;
    logic             mode_q;
    logic             tc_next;
    logic             flag_next;
    logic             advance;
    logic             do_start;

    assign do_start       = start && !stop;
    assign terminal_value = limit_q - 1'b1;

`ifdef TIMER_PRESCALER_EN
    logic [PRESCALE_BITS-1:0] prescale_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        prescale_q <= '0;
        else if (do_start) prescale_q <= prescale;
    end

    // A fresh start reloads with the incoming prescale so the first step already uses it.
    prescaler_tick #(
        .WIDTH (PRESCALE_BITS)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (start || stop),
        .enable (state == RUN),
        .reload (do_start ? prescale : prescale_q),
        .tick   (advance)
    );
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        count_next = count;
        tc_next    = 1'b0;
        flag_next  = flag && !clear_flag;

        if (stop) begin
            state_next = IDLE;
            count_next = '0;
        end else if (start) begin
            state_next = RUN;
            count_next = '0;
        end else if (state == RUN && advance) begin
            if (count == terminal_value) begin
                tc_next   = 1'b1;
                flag_next = 1'b1;
                if (mode_q == MODE_ONESHOT) state_next = DONE;
                else                        count_next = '0;
            end else begin
                count_next = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            tc      <= 1'b0;
            flag    <= 1'b0;
            limit_q <= '0;
            mode_q  <= MODE_PERIODIC;
        end else begin
            state <= state_next;
            count <= count_next;
            tc    <= tc_next;
            flag  <= flag_next;
            if (do_start) begin
                limit_q <= limit;
                mode_q  <= mode;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_timer_counter_flag.sv
// Directed self-checking bench for timer_counter_flag (NBITS=4); prescaler steps run with TIMER_PRESCALER_EN.
module tb_timer_counter_flag;

    localparam int NBITS = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             mode;
    logic [NBITS-1:0] limit;
`ifdef TIMER_PRESCALER_EN
    logic [7:0]       prescale;
`endif
    logic             clear_flag;
    logic [NBITS-1:0] count;
    logic             tc;
    logic             flag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    timer_counter_flag #(
        .NBITS (NBITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .limit      (limit),
`ifdef TIMER_PRESCALER_EN
        .prescale   (prescale),
`endif
        .clear_flag (clear_flag),
        .count      (count),
        .tc         (tc),
        .flag       (flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input int exp_count, input logic exp_tc,
                             input logic exp_flag, input logic exp_busy);
        check({tag, ".count"}, 32'(count), 32'(exp_count));
        check({tag, ".tc"},    32'(tc),    32'(exp_tc));
        check({tag, ".flag"},  32'(flag),  32'(exp_flag));
        check({tag, ".busy"},  32'(busy),  32'(exp_busy));
    endtask

    // Advance one clock edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        mode       = 1'b0;
        limit      = '0;
        clear_flag = 1'b0;
`ifdef TIMER_PRESCALER_EN
        prescale   = '0;
`endif
        #2;
        check_all("reset", 0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        check_all("idle", 0, 1'b0, 1'b0, 1'b0);

        // Periodic L=5 over 30 edges.
        limit = 4'd5;
        mode  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("per5.e0", 0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            step();
            check_all($sformatf("per5.e%0d", k), k % 5, (k % 5) == 0, k >= 5, 1'b1);
        end

        // Clear flag alone, then coincident with tc.
        clear_flag = 1'b1;
        step();
        clear_flag = 1'b0;
        check_all("clr.e31", 1, 1'b0, 1'b0, 1'b1);
        step();
        step();
        step();
        check_all("clr.e34", 4, 1'b0, 1'b0, 1'b1);
        clear_flag = 1'b1;
        step();
        clear_flag = 1'b0;
        check_all("clr_tc.e35", 0, 1'b1, 1'b1, 1'b1);

        // Restart mid-run at count=3.
        step();
        step();
        step();
        check("mid.count3", 32'(count), 32'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("mid.restart", 0, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) step();
        check_all("mid.e4", 4, 1'b0, 1'b1, 1'b1);
        step();
        check_all("mid.e5", 0, 1'b1, 1'b1, 1'b1);

        // start and stop together: stop wins.
        step();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check_all("startstop", 0, 1'b0, 1'b1, 1'b0);
        step();
        check_all("startstop.hold", 0, 1'b0, 1'b1, 1'b0);

        // One-shot L=3.
        limit = 4'd3;
        mode  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("os.e0", 0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        check_all("os.e2", 2, 1'b0, 1'b1, 1'b1);
        step();
        check_all("os.e3", 2, 1'b1, 1'b1, 1'b0);
        step();
        check_all("os.done", 2, 1'b0, 1'b1, 1'b0);
        step();
        check_all("os.done2", 2, 1'b0, 1'b1, 1'b0);

        // Second start; limit/mode changes mid-run must be ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        limit = 4'd9;
        mode  = 1'b0;
        check_all("os2.e0", 0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        check_all("os2.e2", 2, 1'b0, 1'b1, 1'b1);
        step();
        check_all("os2.e3", 2, 1'b1, 1'b1, 1'b0);

        // stop from DONE.
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_all("stop_done", 0, 1'b0, 1'b1, 1'b0);

        // L=1 periodic: tc every advance, count stays 0.
        limit = 4'd1;
        mode  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("l1.e0", 0, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_all($sformatf("l1.e%0d", k), 0, 1'b1, 1'b1, 1'b1);
        end

        // L=0 periodic: full 16-count range.
        limit = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("l0.e0", 0, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            step();
            check_all($sformatf("l0.e%0d", k), k % 16, (k % 16) == 0, 1'b1, 1'b1);
        end

        // Asynchronous reset at count=7.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        check_all("rst.pre", 7, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        #1;
        check_all("rst.async", 0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        step();
        check_all("rst.idle", 0, 1'b0, 1'b0, 1'b0);

`ifdef TIMER_PRESCALER_EN
        // Prescale P=2, L=4: count steps every 3 cycles, tc every 12.
        prescale = 8'd2;
        limit    = 4'd4;
        mode     = 1'b0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check_all("ps.e0", 0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            step();
            check_all($sformatf("ps.e%0d", k), (k / 3) % 4, (k % 12) == 0, k >= 12, 1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
